// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D memory port arbiter: FSM encodings, requester IDs
// and the default abort timeout.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    localparam int ARB_TIMEOUT_DEF = 255;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin pick between fetch and data sides; the last-served side
// loses a tie and is updated only when the caller strobes a grant.
module arb_rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    req_i,
    input  logic    req_d,
    input  logic    grant_stb,
    output req_id_e winner
);

    req_id_e last_q;
    req_id_e last_d;

    always_comb begin
        winner = REQ_I;
        if (req_i && req_d) begin
            winner = (last_q == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            winner = REQ_D;
        end
        last_d = grant_stb ? winner : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_I;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data sides.
// Optional abort-on-timeout is built when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iI_REQ,
    input  logic [ADDR_W-1:0]   iI_ADDR,
    output logic                oI_GNT,
    output logic                oI_RVALID,
    output logic [DATA_W-1:0]   oI_RDATA,
    output logic                oI_ERR,
    input  logic                iD_REQ,
    input  logic                iD_WE,
    input  logic [DATA_W/8-1:0] iD_BE,
    input  logic [ADDR_W-1:0]   iD_ADDR,
    input  logic [DATA_W-1:0]   iD_WDATA,
    output logic                oD_GNT,
    output logic                oD_RVALID,
    output logic [DATA_W-1:0]   oD_RDATA,
    output logic                oD_ERR,
    output logic                oM_REQ,
    output logic                oM_WE,
    output logic [DATA_W/8-1:0] oM_BE,
    output logic [ADDR_W-1:0]   oM_ADDR,
    output logic [DATA_W-1:0]   oM_WDATA,
    input  logic                iM_GNT,
    input  logic                iM_RVALID,
    input  logic [DATA_W-1:0]   iM_RDATA
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    req_id_e           owner_q, owner_d;
    req_id_e           winner;
    logic              grant_stb, done, abort, timeout_hit;
    logic              i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
    logic              m_req_q, m_req_d, m_we_q, m_we_d;
    logic [BE_W-1:0]   m_be_q, m_be_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

    arb_rr_pick u_pick (
        .clk       (iCLK),
        .rst       (iRST),
        .req_i     (iI_REQ),
        .req_d     (iD_REQ),
        .grant_stb (grant_stb),
        .winner    (winner)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        grant_stb  = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        i_gnt_d    = 1'b0;
        d_gnt_d    = 1'b0;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_be_d     = m_be_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (iI_REQ || iD_REQ) begin
                    grant_stb = 1'b1;
                    owner_d   = winner;
                    state_d   = ARB_REQ;
                    m_req_d   = 1'b1;
                    if (winner == REQ_D) begin
                        d_gnt_d   = 1'b1;
                        m_we_d    = iD_WE;
                        m_be_d    = iD_BE;
                        m_addr_d  = iD_ADDR;
                        m_wdata_d = iD_WDATA;
                    end else begin
                        i_gnt_d   = 1'b1;
                        m_we_d    = 1'b0;
                        m_be_d    = '0;
                        m_addr_d  = iI_ADDR;
                        m_wdata_d = '0;
                    end
                end
            end
            ARB_REQ: begin
                if (timeout_hit) begin
                    abort = 1'b1;
                end else if (iM_GNT) begin
                    state_d = ARB_WAIT;
                    m_req_d = 1'b0;
                end
            end
            ARB_WAIT: begin
                // A real response arriving on the last allowed cycle beats the abort.
                if (iM_RVALID) begin
                    done = 1'b1;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (done || abort) begin
            state_d = ARB_IDLE;
            m_req_d = 1'b0;
            if (owner_q == REQ_D) begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = (abort || m_we_q) ? '0 : iM_RDATA;
            end else begin
                i_rvalid_d = 1'b1;
                i_rdata_d  = abort ? '0 : iM_RDATA;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= ARB_IDLE;
            owner_q    <= REQ_I;
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_be_q     <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            i_gnt_q    <= i_gnt_d;
            d_gnt_q    <= d_gnt_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_be_q     <= m_be_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        i_err_q, i_err_d, d_err_q, d_err_d;

    // Held at zero while idle so it starts from zero on every entry to REQ.
    always_comb begin
        cnt_d   = (state_q == ARB_IDLE) ? 16'd0 : cnt_q + 16'd1;
        i_err_d = abort && (owner_q == REQ_I);
        d_err_d = abort && (owner_q == REQ_D);
    end

    assign timeout_hit = (state_q != ARB_IDLE) && (cnt_q == TO_LAST);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt_q   <= '0;
            i_err_q <= 1'b0;
            d_err_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            i_err_q <= i_err_d;
            d_err_q <= d_err_d;
        end
    end

    assign oI_ERR = i_err_q;
    assign oD_ERR = d_err_q;
`else
    assign timeout_hit = 1'b0;
    assign oI_ERR      = 1'b0;
    assign oD_ERR      = 1'b0;
`endif

    assign oI_GNT    = i_gnt_q;
    assign oI_RVALID = i_rvalid_q;
    assign oI_RDATA  = i_rdata_q;
    assign oD_GNT    = d_gnt_q;
    assign oD_RVALID = d_rvalid_q;
    assign oD_RDATA  = d_rdata_q;
    assign oM_REQ    = m_req_q;
    assign oM_WE     = m_we_q;
    assign oM_BE     = m_be_q;
    assign oM_ADDR   = m_addr_q;
    assign oM_WDATA  = m_wdata_q;

endmodule
